// File: rtl/seven_seg_cmd_queue.sv
// seven_seg_cmd_queue: bus-fed 4-entry command FIFO that shows each command for a programmable number of dwell ticks.
module seven_seg_cmd_queue #(
    parameter logic [7:0] BASE_ADDR  = 8'hD0,
    parameter int         TICK_DIV   = 10_000_000,
    parameter int         TICK_WIDTH = 24
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic [3:0] COMMAND,
    output logic       BUSY,
    output logic [2:0] FIFO_COUNT,
    output logic       OVERFLOW
);
    typedef enum logic {IDLE, SHOW} state_t;
    state_t state, state_nxt;
    logic [TICK_WIDTH-1:0] pre;
    logic [3:0] mem [4];
    logic [1:0] wp, rp;
    logic [7:0] dwell, dcnt, dload;
    logic tick, we_push, we_dwell, we_ctrl, flush, push, pop, empty, full, dwell_done;
    assign tick       = pre == TICK_WIDTH'(TICK_DIV - 1);
    assign we_push    = BUS_WE && BUS_ADDR == BASE_ADDR;
    assign we_dwell   = BUS_WE && BUS_ADDR == BASE_ADDR + 8'd1;
    assign we_ctrl    = BUS_WE && BUS_ADDR == BASE_ADDR + 8'd2;
    assign flush      = we_ctrl && BUS_DATA[0];
    assign empty      = FIFO_COUNT == 3'd0;
    assign full       = FIFO_COUNT == 3'd4;
    assign dwell_done = tick && dcnt <= 8'd1;
    assign dload      = dwell == 8'd0 ? 8'd1 : dwell;
    // a pop in the same cycle frees a slot, so a push into a full FIFO still fits
    assign push       = we_push && (!full || pop);
    always_ff @(posedge CLK) begin
        state <= RESET ? IDLE : state_nxt;
    end
    always_comb begin
        state_nxt = flush ? IDLE :
                    state == IDLE ? (empty ? IDLE : SHOW) :
                    (dwell_done && empty) ? IDLE : SHOW;
    end
    always_comb begin
        pop  = !flush && !empty && (state == IDLE || dwell_done);
        BUSY = state == SHOW;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pre        <= '0;
            wp         <= '0;
            rp         <= '0;
            FIFO_COUNT <= '0;
            COMMAND    <= '0;
            OVERFLOW   <= 1'b0;
            dwell      <= 8'd10;
            dcnt       <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (push) begin
                mem[wp] <= BUS_DATA[3:0];
                wp      <= wp + 2'd1;
            end
            if (pop) begin
                COMMAND <= mem[rp];
                rp      <= rp + 2'd1;
            end
            if (we_dwell)
                dwell <= BUS_DATA;
            if (we_push && full && !pop)
                OVERFLOW <= 1'b1;
            else if (we_ctrl && BUS_DATA[1])
                OVERFLOW <= 1'b0;
            if (flush) begin
                wp         <= '0;
                rp         <= '0;
                FIFO_COUNT <= '0;
                dcnt       <= '0;
            end else begin
                FIFO_COUNT <= FIFO_COUNT + 3'(push) - 3'(pop);
                if (pop)
                    dcnt <= dload;
                else if (state == SHOW && tick)
                    dcnt <= dcnt - 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_cmd_queue.sv
// tb_seven_seg_cmd_queue: scoreboard bench; expected commands are queued at push time and matched on every COMMAND change.
module tb_seven_seg_cmd_queue;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] BUS_ADDR = '0;
    logic [7:0] BUS_DATA = '0;
    logic       BUS_WE = 1'b0;
    logic [3:0] COMMAND;
    logic       BUSY;
    logic [2:0] FIFO_COUNT;
    logic       OVERFLOW;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int idle_t = 0;
    logic [3:0] prev_cmd = '0;
    logic [3:0] exp_q [$];
    int chg_t [$];

    seven_seg_cmd_queue #(.BASE_ADDR(8'hD0), .TICK_DIV(4), .TICK_WIDTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA), .BUS_WE(BUS_WE),
        .COMMAND(COMMAND), .BUSY(BUSY), .FIFO_COUNT(FIFO_COUNT), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET)
            prev_cmd = COMMAND;
        else if (COMMAND !== prev_cmd) begin
            chg_t.push_back(cyc);
            if (exp_q.size() == 0)
                check("cmd_unexpected", 32'(COMMAND), 32'(prev_cmd));
            else
                check("cmd_order", 32'(COMMAND), 32'(exp_q.pop_front()));
            prev_cmd = COMMAND;
        end
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        BUS_ADDR = a;
        BUS_DATA = d;
        BUS_WE = 1'b1;
        @(posedge CLK);
        #1;
        BUS_WE = 1'b0;
    endtask

    task automatic push_exp(input logic [3:0] v);
        exp_q.push_back(v);
        wr(8'hD0, {4'h0, v});
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (BUSY !== 1'b0 && n < lim) begin
            @(posedge CLK);
            #1;
            n++;
        end
        idle_t = cyc;
        check("idle_timeout", 32'(n < lim), 32'd1);
    endtask

    task automatic wait_cmd_change(input int lim);
        logic [3:0] c0 = COMMAND;
        int n = 0;
        while (COMMAND === c0 && n < lim) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("change_timeout", 32'(n < lim), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("rst_command", 32'(COMMAND), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_count", 32'(FIFO_COUNT), 32'd0);
        check("rst_overflow", 32'(OVERFLOW), 32'd0);
        // first command reaches COMMAND one cycle after its push edge
        push_exp(4'h5);
        check("push_count", 32'(FIFO_COUNT), 32'd1);
        check("push_busy", 32'(BUSY), 32'd0);
        @(posedge CLK);
        #1;
        check("show_command", 32'(COMMAND), 32'h5);
        check("show_busy", 32'(BUSY), 32'd1);
        check("show_count", 32'(FIFO_COUNT), 32'd0);
        wait_idle(200);
        // dwell of 2 ticks = 8 cycles between back-to-back pops
        wr(8'hD1, 8'd2);
        chg_t.delete();
        push_exp(4'h1);
        push_exp(4'h2);
        push_exp(4'h3);
        wait_idle(200);
        check("seq_changes", 32'(chg_t.size()), 32'd3);
        if (chg_t.size() == 3) begin
            check("hold_2", 32'(chg_t[2] - chg_t[1]), 32'd8);
            check("hold_3", 32'(idle_t - chg_t[2]), 32'd8);
        end
        check("idle_keeps_cmd", 32'(COMMAND), 32'h3);
        check("idle_count", 32'(FIFO_COUNT), 32'd0);
        // overflow while a long dwell holds the FIFO
        wr(8'hD1, 8'd50);
        push_exp(4'h6);
        @(posedge CLK);
        #1;
        check("ovf_busy", 32'(BUSY), 32'd1);
        for (int i = 0; i < 4; i++) push_exp(4'(7 + i));
        wr(8'hD0, 8'h0B);
        check("ovf_count", 32'(FIFO_COUNT), 32'd4);
        check("ovf_flag", 32'(OVERFLOW), 32'd1);
        wr(8'hD2, 8'h02);
        check("ovf_clear", 32'(OVERFLOW), 32'd0);
        check("ovf_clear_count", 32'(FIFO_COUNT), 32'd4);
        // full FIFO with a push on the pop-tick cycle
        wr(8'hD1, 8'd1);
        wait_cmd_change(400);
        push_exp(4'hC);
        check("refill_count", 32'(FIFO_COUNT), 32'd4);
        repeat (2) @(posedge CLK);
        #1;
        push_exp(4'hD);
        check("full_pushpop_count", 32'(FIFO_COUNT), 32'd4);
        check("full_pushpop_ovf", 32'(OVERFLOW), 32'd0);
        repeat (4) @(posedge CLK);
        #1;
        check("three_queued", 32'(FIFO_COUNT), 32'd3);
        check("pre_flush_cmd", 32'(COMMAND), 32'h9);
        wr(8'hD2, 8'h01);
        exp_q.delete();
        check("flush_count", 32'(FIFO_COUNT), 32'd0);
        check("flush_busy", 32'(BUSY), 32'd0);
        check("flush_cmd", 32'(COMMAND), 32'h9);
        wr(8'hD3, 8'h05);
        wr(8'hCF, 8'h05);
        repeat (3) @(posedge CLK);
        #1;
        check("stray_count", 32'(FIFO_COUNT), 32'd0);
        check("stray_busy", 32'(BUSY), 32'd0);
        check("stray_cmd", 32'(COMMAND), 32'h9);
        // reset mid-SHOW with a simultaneous push
        wr(8'hD1, 8'd20);
        push_exp(4'h1);
        for (int i = 0; i < 5; i++) push_exp(4'(2 + i));
        check("pre_rst_busy", 32'(BUSY), 32'd1);
        check("pre_rst_ovf", 32'(OVERFLOW), 32'd1);
        RESET = 1'b1;
        BUS_ADDR = 8'hD0;
        BUS_DATA = 8'h0E;
        BUS_WE = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        BUS_WE = 1'b0;
        exp_q.delete();
        prev_cmd = '0;
        check("mid_rst_command", 32'(COMMAND), 32'd0);
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        check("mid_rst_count", 32'(FIFO_COUNT), 32'd0);
        check("mid_rst_ovf", 32'(OVERFLOW), 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        check("rst_drop_count", 32'(FIFO_COUNT), 32'd0);
        check("rst_drop_busy", 32'(BUSY), 32'd0);
        // DWELL=0 behaves as a one-tick dwell
        wr(8'hD1, 8'd0);
        chg_t.delete();
        push_exp(4'h7);
        push_exp(4'h8);
        wait_idle(100);
        check("dwell0_changes", 32'(chg_t.size()), 32'd2);
        if (chg_t.size() == 2)
            check("dwell0_hold", 32'(idle_t - chg_t[1]), 32'd4);
        check("dwell0_cmd", 32'(COMMAND), 32'h8);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seven_seg_cmd_queue.md
SEVEN_SEG_CMD_QUEUE -- requirements
Module: seven_seg_cmd_queue

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'hD0: base of the three-register bus window (BASE_ADDR+0..+2).
REQ-002 SHALL have parameter TICK_DIV, default 10_000_000: CLK cycles per dwell tick (10 Hz at 100 MHz).
REQ-003 SHALL have parameter TICK_WIDTH, default 24: width of the tick prescaler counter.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port BUS_ADDR, input, 8 bits: bus address.
REQ-007 SHALL have port BUS_DATA, input, 8 bits: bus write data.
REQ-008 SHALL have port BUS_WE, input, 1 bit: bus write strobe, one CLK cycle per write.
REQ-009 SHALL have port COMMAND, output, 4 bits: registered command for the downstream seven-segment display stage.
REQ-010 SHALL have port BUSY, output, 1 bit: high while in state SHOW.
REQ-011 SHALL have port FIFO_COUNT, output, 3 bits: queue occupancy, 0..4.
REQ-012 SHALL have port OVERFLOW, output, 1 bit: sticky flag for a dropped push.

Function
REQ-013 SHALL decode writes only when BUS_WE=1 and BUS_ADDR is in BASE_ADDR..BASE_ADDR+2; other addresses are ignored.
REQ-014 SHALL treat a write to BASE_ADDR+0 as a push of BUS_DATA[3:0] into a 4-entry FIFO; BUS_DATA[7:4] are ignored.
REQ-015 SHALL load BUS_DATA into the 8-bit DWELL register on a write to BASE_ADDR+1; a new value affects only later reloads.
REQ-016 SHALL treat a write to BASE_ADDR+2 as control: bit0=1 flushes the FIFO and forces IDLE; bit1=1 clears OVERFLOW; other bits are ignored.
REQ-017 SHALL run a free-running prescaler counting 0..TICK_DIV-1 and wrapping; tick is a 1-cycle pulse at count TICK_DIV-1.
REQ-018 SHALL implement a two-state FSM, IDLE and SHOW.
REQ-019 In IDLE with FIFO non-empty, SHALL pop the head into COMMAND, load the dwell counter from DWELL, and enter SHOW at the same edge.
REQ-020 SHALL make COMMAND change exactly one cycle after the push edge when the push reaches an empty FIFO in IDLE.
REQ-021 In SHOW, on each tick with dwell counter >1, SHALL decrement the dwell counter.
REQ-022 In SHOW, on a tick with dwell counter =1: if the FIFO is non-empty, SHALL pop the next entry into COMMAND, reload, and stay in SHOW; otherwise SHALL go to IDLE.
REQ-023 SHALL treat DWELL=0 as 1 when loading the dwell counter.
REQ-024 SHALL hold COMMAND at its last value in IDLE, including after a flush.
REQ-025 For a push when FIFO_COUNT=4 with no pop in the same cycle, SHALL drop the data, leave the FIFO unchanged, and set OVERFLOW.
REQ-026 For a push and a pop in the same cycle, SHALL perform both and leave FIFO_COUNT unchanged; this includes the full case, with no overflow.
REQ-027 SHALL let the flush override any pop in the same cycle: FIFO_COUNT=0, state IDLE, dwell counter 0.
REQ-028 SHALL wrap FIFO pointers modulo 4 and keep order strictly first-in, first-out.

Reset
REQ-029 On RESET=1 at a CLK edge, SHALL set: COMMAND=0, state=IDLE, BUSY=0, FIFO_COUNT=0, pointers=0, OVERFLOW=0, DWELL=8'd10, dwell counter=0, prescaler=0.
REQ-030 Reset SHALL override any simultaneous bus write, including mid-SHOW.

Verification (TICK_DIV=4)
REQ-031 Reset, then push 4'h5 to D0 -> COMMAND=5 one cycle after the write, BUSY=1, FIFO_COUNT=0.
REQ-032 DWELL=2, then push 1,2,3 back-to-back -> COMMAND steps 1->2->3, each held 2 ticks (about 8 cycles), then BUSY=0 and COMMAND stays 3.
REQ-033 In SHOW, push 5 entries with no tick -> FIFO_COUNT=4, OVERFLOW=1, the 5th value never appears; write D2=8'h02 -> OVERFLOW=0.
REQ-034 FIFO_COUNT=4 with a push on the pop-tick cycle -> FIFO_COUNT stays 4, OVERFLOW stays 0, order preserved.
REQ-035 Write D2=8'h01 mid-SHOW with 3 queued -> FIFO_COUNT=0, BUSY=0, COMMAND unchanged; writes to D3 and CF have no effect.
REQ-036 Assert RESET mid-SHOW with a simultaneous D0 write -> all outputs at their reset values next cycle, and the push is dropped.
